// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order reorder buffer for the out-of-order core.
// Entries are allocated at dispatch, filled from the arithmetic and LS CDBs,
// and retired one per cycle in program order to the register file.
// Build option: define ROB_FLUSH_EN to make the flush port clear the buffer;
// without it the flush port is accepted but has no effect.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int ROB_ID_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                alloc_valid,
  input  logic [4:0]          alloc_rd,
  output logic [ROB_ID_W-1:0] alloc_rob_id,
  output logic                rob_full,
  input  logic                valid_from_Arith_unit_cdb,
  input  logic [ROB_ID_W-1:0] rob_id_from_Arith_unit_cdb,
  input  logic [31:0]         result_from_Arith_unit_cdb,
  input  logic                valid_from_LS_unit_cdb,
  input  logic [ROB_ID_W-1:0] rob_id_from_LS_unit_cdb,
  input  logic [31:0]         result_from_LS_unit_cdb,
  input  logic [ROB_ID_W-1:0] Q1_query,
  input  logic [ROB_ID_W-1:0] Q2_query,
  output logic                Q1_ready_from_rob,
  output logic                Q2_ready_from_rob,
  output logic [31:0]         V1_result_from_rob,
  output logic [31:0]         V2_result_from_rob,
  output logic                commit_valid,
  output logic [4:0]          commit_rd,
  output logic [31:0]         commit_value,
  output logic [ROB_ID_W-1:0] commit_rob_id,
  input  logic                flush
);

  localparam int CNT_W = $clog2(ROB_SIZE + 1);
  localparam logic [ROB_ID_W-1:0] ZERO_ROB  = '0;
  localparam logic [ROB_ID_W-1:0] FIRST_ROB = ROB_ID_W'(1);
  localparam logic [ROB_ID_W-1:0] LAST_ROB  = ROB_ID_W'(ROB_SIZE);

  // Per-entry state; IDs run 1..ROB_SIZE, ID 0 means "no dependency".
  logic [ROB_SIZE:1] busy_q, busy_d;
  logic [ROB_SIZE:1] ready_q, ready_d;
  logic [4:0]        rd_q    [1:ROB_SIZE];
  logic [4:0]        rd_d    [1:ROB_SIZE];
  logic [31:0]       value_q [1:ROB_SIZE];
  logic [31:0]       value_d [1:ROB_SIZE];

  logic [ROB_ID_W-1:0] head_q, head_d;
  logic [ROB_ID_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                commit_valid_q, commit_valid_d;
  logic [4:0]          commit_rd_q, commit_rd_d;
  logic [31:0]         commit_value_q, commit_value_d;
  logic [ROB_ID_W-1:0] commit_rob_id_q, commit_rob_id_d;

  logic alloc_fire, commit_fire, flush_fire;
  logic [ROB_SIZE:1] alloc_sel, arith_sel, ls_sel, commit_sel;
  logic q1_hit, q2_hit;

  // Wrap from the last ID back to 1; ID 0 is never handed out.
  function automatic logic [ROB_ID_W-1:0] next_id(input logic [ROB_ID_W-1:0] id);
    return (id == LAST_ROB) ? FIRST_ROB : id + FIRST_ROB;
  endfunction

  assign rob_full    = (count_q == CNT_W'(ROB_SIZE));
  assign alloc_fire  = rdy && alloc_valid && !rob_full;
  assign commit_fire = rdy && busy_q[head_q] && ready_q[head_q];

`ifdef ROB_FLUSH_EN
  assign flush_fire = rdy && flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_fire   = 1'b0;
`endif

  // Per-entry decode of allocate, CDB writeback and commit targets.
  // A CDB only lands on an entry that is busy before this edge.
  genvar gi;
  generate
    for (gi = 1; gi <= ROB_SIZE; gi++) begin : g_sel
      localparam logic [ROB_ID_W-1:0] ENTRY_ID = ROB_ID_W'(gi);
      assign alloc_sel[gi]  = alloc_fire && (tail_q == ENTRY_ID);
      assign arith_sel[gi]  = rdy && valid_from_Arith_unit_cdb &&
                              (rob_id_from_Arith_unit_cdb == ENTRY_ID) && busy_q[gi];
      assign ls_sel[gi]     = rdy && valid_from_LS_unit_cdb &&
                              (rob_id_from_LS_unit_cdb == ENTRY_ID) && busy_q[gi];
      assign commit_sel[gi] = commit_fire && (head_q == ENTRY_ID);
    end
  endgenerate

  // Entry next state: writeback (LS applied last so it wins a tag clash),
  // commit clears busy, allocate re-arms the tail entry, flush clears all.
  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    rd_d    = rd_q;
    value_d = value_q;
    for (int i = 1; i <= ROB_SIZE; i++) begin
      if (arith_sel[i]) begin
        ready_d[i] = 1'b1;
        value_d[i] = result_from_Arith_unit_cdb;
      end
      if (ls_sel[i]) begin
        ready_d[i] = 1'b1;
        value_d[i] = result_from_LS_unit_cdb;
      end
      if (commit_sel[i]) begin
        busy_d[i] = 1'b0;
      end
      if (alloc_sel[i]) begin
        busy_d[i]  = 1'b1;
        ready_d[i] = 1'b0;
        rd_d[i]    = alloc_rd;
      end
    end
    if (flush_fire) begin
      busy_d  = '0;
      ready_d = '0;
    end
  end

  // Pointer, occupancy and commit-port next state; commit data holds
  // its last value whenever no entry retires.
  always_comb begin
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    commit_valid_d  = 1'b0;
    commit_rd_d     = commit_rd_q;
    commit_value_d  = commit_value_q;
    commit_rob_id_d = commit_rob_id_q;
    if (flush_fire) begin
      head_d  = FIRST_ROB;
      tail_d  = FIRST_ROB;
      count_d = '0;
    end else begin
      if (commit_fire) begin
        commit_valid_d  = 1'b1;
        commit_rd_d     = rd_q[head_q];
        commit_value_d  = value_q[head_q];
        commit_rob_id_d = head_q;
        head_d          = next_id(head_q);
      end
      if (alloc_fire) begin
        tail_d = next_id(tail_q);
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register with asynchronous reset to the empty buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      ready_q <= '0;
      for (int i = 1; i <= ROB_SIZE; i++) begin
        rd_q[i]    <= '0;
        value_q[i] <= '0;
      end
      head_q          <= FIRST_ROB;
      tail_q          <= FIRST_ROB;
      count_q         <= '0;
      commit_valid_q  <= 1'b0;
      commit_rd_q     <= '0;
      commit_value_q  <= '0;
      commit_rob_id_q <= '0;
    end else begin
      busy_q          <= busy_d;
      ready_q         <= ready_d;
      rd_q            <= rd_d;
      value_q         <= value_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      commit_valid_q  <= commit_valid_d;
      commit_rd_q     <= commit_rd_d;
      commit_value_q  <= commit_value_d;
      commit_rob_id_q <= commit_rob_id_d;
    end
  end

  // Operand queries from registered state; tag 0 and out-of-range tags miss.
  always_comb begin
    q1_hit = (Q1_query != ZERO_ROB) && (Q1_query <= LAST_ROB);
    q2_hit = (Q2_query != ZERO_ROB) && (Q2_query <= LAST_ROB);
    Q1_ready_from_rob  = q1_hit && busy_q[Q1_query] && ready_q[Q1_query];
    Q2_ready_from_rob  = q2_hit && busy_q[Q2_query] && ready_q[Q2_query];
    V1_result_from_rob = Q1_ready_from_rob ? value_q[Q1_query] : 32'd0;
    V2_result_from_rob = Q2_ready_from_rob ? value_q[Q2_query] : 32'd0;
  end

  assign alloc_rob_id  = tail_q;
  assign commit_valid  = commit_valid_q;
  assign commit_rd     = commit_rd_q;
  assign commit_value  = commit_value_q;
  assign commit_rob_id = commit_rob_id_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios followed by random traffic, every
// cycle compared against a queue-based model of the in-flight instructions.
module tb_reorder_buffer;

  localparam int ROB_SIZE = 16;
  localparam int ROB_ID_W = 5;

  logic                clk, rst, rdy;
  logic                alloc_valid;
  logic [4:0]          alloc_rd;
  logic [ROB_ID_W-1:0] alloc_rob_id;
  logic                rob_full;
  logic                valid_a, valid_l;
  logic [ROB_ID_W-1:0] id_a, id_l;
  logic [31:0]         res_a, res_l;
  logic [ROB_ID_W-1:0] Q1_query, Q2_query;
  logic                Q1_ready, Q2_ready;
  logic [31:0]         V1, V2;
  logic                commit_valid;
  logic [4:0]          commit_rd;
  logic [31:0]         commit_value;
  logic [ROB_ID_W-1:0] commit_rob_id;
  logic                flush;

  reorder_buffer #(.ROB_SIZE(ROB_SIZE), .ROB_ID_W(ROB_ID_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_rob_id(alloc_rob_id), .rob_full(rob_full),
    .valid_from_Arith_unit_cdb(valid_a), .rob_id_from_Arith_unit_cdb(id_a),
    .result_from_Arith_unit_cdb(res_a),
    .valid_from_LS_unit_cdb(valid_l), .rob_id_from_LS_unit_cdb(id_l),
    .result_from_LS_unit_cdb(res_l),
    .Q1_query(Q1_query), .Q2_query(Q2_query),
    .Q1_ready_from_rob(Q1_ready), .Q2_ready_from_rob(Q2_ready),
    .V1_result_from_rob(V1), .V2_result_from_rob(V2),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_rob_id(commit_rob_id),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: program-ordered list of in-flight IDs plus per-ID data.
  int          q[$];
  bit          m_ready [0:31];
  logic [31:0] m_val   [0:31];
  logic [4:0]  m_rd    [0:31];
  int          m_tail;
  logic        e_cv;
  logic [4:0]  e_rd;
  logic [31:0] e_val;
  int          e_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit inflight(input int id);
    foreach (q[i]) if (q[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int nxt(input int id);
    return (id == ROB_SIZE) ? 1 : id + 1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_tail = 1;
    e_cv = 1'b0; e_rd = '0; e_val = '0; e_id = 0;
  endtask

  // Applies the inputs present at a rising edge to the model.
  task automatic model_edge();
    automatic bit full      = (q.size() == ROB_SIZE);
    automatic bit do_commit = rdy && (q.size() > 0) && m_ready[q[0]];
    automatic bit do_alloc  = rdy && alloc_valid && !full;
    automatic bit wr_a      = rdy && valid_a && inflight(int'(id_a));
    automatic bit wr_l      = rdy && valid_l && inflight(int'(id_l));
`ifdef ROB_FLUSH_EN
    if (rdy && flush) begin
      q.delete();
      m_tail = 1;
      e_cv = 1'b0;
      return;
    end
`endif
    e_cv = do_commit;
    if (do_commit) begin
      e_rd  = m_rd[q[0]];
      e_val = m_val[q[0]];
      e_id  = q[0];
    end
    if (wr_a) begin m_ready[id_a] = 1'b1; m_val[id_a] = res_a; end
    if (wr_l) begin m_ready[id_l] = 1'b1; m_val[id_l] = res_l; end
    if (do_commit) void'(q.pop_front());
    if (do_alloc) begin
      q.push_back(m_tail);
      m_ready[m_tail] = 1'b0;
      m_rd[m_tail]    = alloc_rd;
      m_tail          = nxt(m_tail);
    end
  endtask

  task automatic check_all();
    automatic bit r1 = (Q1_query != 0) && inflight(int'(Q1_query)) && m_ready[Q1_query];
    automatic bit r2 = (Q2_query != 0) && inflight(int'(Q2_query)) && m_ready[Q2_query];
    chk("alloc_rob_id", alloc_rob_id, m_tail);
    chk("rob_full", rob_full, q.size() == ROB_SIZE);
    chk("commit_valid", commit_valid, e_cv);
    chk("commit_rd", commit_rd, e_rd);
    chk("commit_value", commit_value, e_val);
    chk("commit_rob_id", commit_rob_id, e_id);
    chk("Q1_ready", Q1_ready, r1);
    chk("Q2_ready", Q2_ready, r2);
    chk("V1", V1, r1 ? m_val[Q1_query] : 32'd0);
    chk("V2", V2, r2 ? m_val[Q2_query] : 32'd0);
    $display("cycle t=%0t alloc_id=%0d full=%0b commit=%0b id=%0d rd=%0d val=%h inflight=%0d",
             $time, alloc_rob_id, rob_full, commit_valid, commit_rob_id, commit_rd,
             commit_value, q.size());
  endtask

  task automatic idle();
    rdy = 1'b1; alloc_valid = 1'b0; alloc_rd = '0; flush = 1'b0;
    valid_a = 1'b0; id_a = '0; res_a = '0;
    valid_l = 1'b0; id_l = '0; res_l = '0;
    Q1_query = '0; Q2_query = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asynchronous reset: outputs must return to reset values before any edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #2;
    do_reset();

    // Three allocations get IDs 1..3.
    for (int r = 5; r <= 7; r++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(r);
      cycle();
    end
    alloc_valid = 1'b0;
    cycle();
    chk("alloc_id_after_3", alloc_rob_id, 4);

    // Arith CDB to ID 2, then LS CDB to ID 1; in-order commits follow.
    valid_a = 1'b1; id_a = 5'd2; res_a = 32'h22; Q1_query = 5'd2;
    cycle();
    chk("q1_ready_id2", Q1_ready, 1);
    chk("v1_id2", V1, 32'h22);
    valid_a = 1'b0; valid_l = 1'b1; id_l = 5'd1; res_l = 32'h11;
    cycle();
    chk("no_early_commit", commit_valid, 0);
    valid_l = 1'b0;
    cycle();
    chk("commit1_id", commit_rob_id, 1);
    chk("commit1_rd", commit_rd, 5);
    chk("commit1_val", commit_value, 32'h11);
    cycle();
    chk("commit2_id", commit_rob_id, 2);
    chk("commit2_val", commit_value, 32'h22);
    cycle();
    chk("id3_no_commit", commit_valid, 0);

    // Reset in the middle of operation, then fill to full.
    do_reset();
    alloc_valid = 1'b1;
    for (int i = 0; i < ROB_SIZE + 1; i++) begin
      alloc_rd = 5'($urandom_range(0, 31));
      cycle();
    end
    chk("full_after_fill", rob_full, 1);
    chk("tail_wrapped", alloc_rob_id, 1);
    valid_a = 1'b1; id_a = 5'd1; res_a = 32'h1234;
    cycle();
    valid_a = 1'b0;
    cycle();
    chk("head_commit", commit_valid, 1);
    chk("alloc_refused_on_commit", alloc_rob_id, 1);
    cycle();
    chk("alloc_after_commit", alloc_rob_id, 2);
    alloc_valid = 1'b0;

    // Both CDBs in one cycle to different entries.
    valid_a = 1'b1; id_a = 5'd4; res_a = 32'hA;
    valid_l = 1'b1; id_l = 5'd9; res_l = 32'hB;
    Q1_query = 5'd4; Q2_query = 5'd9;
    cycle();
    valid_a = 1'b0; valid_l = 1'b0;
    chk("dual_v1", V1, 32'hA);
    chk("dual_v2", V2, 32'hB);
    cycle();

    // Tag 0, non-busy tag and a CDB to a non-busy entry.
    do_reset();
    alloc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin alloc_rd = 5'(i); cycle(); end
    alloc_valid = 1'b0;
    Q1_query = 5'd0; Q2_query = 5'd7;
    valid_a = 1'b1; id_a = 5'd7; res_a = 32'hDEAD;
    cycle();
    valid_a = 1'b0;
    cycle();
    chk("nonbusy_ready", Q2_ready, 0);
    chk("nonbusy_commit", commit_valid, 0);

    // Flush with five busy entries and a simultaneous allocation.
    do_reset();
    alloc_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin alloc_rd = 5'(i + 1); cycle(); end
    flush = 1'b1;
    cycle();
    flush = 1'b0; alloc_valid = 1'b0;
`ifdef ROB_FLUSH_EN
    chk("flush_tail", alloc_rob_id, 1);
`else
    chk("flush_ignored_tail", alloc_rob_id, 7);
`endif

    // Random traffic including stalls and occasional flushes.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      rdy         = ($urandom_range(0, 9) != 0);
      alloc_valid = ($urandom_range(0, 2) != 0);
      alloc_rd    = 5'($urandom_range(0, 31));
      flush       = ($urandom_range(0, 59) == 0);
      valid_a     = $urandom_range(0, 1) != 0;
      valid_l     = $urandom_range(0, 1) != 0;
      id_a  = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
              5'(q[$urandom_range(0, q.size() - 1)]) : 5'($urandom_range(0, 20));
      id_l  = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
              5'(q[$urandom_range(0, q.size() - 1)]) : 5'($urandom_range(0, 20));
      res_a = $urandom;
      res_l = $urandom;
      Q1_query = (q.size() > 0 && $urandom_range(0, 1) != 0) ?
                 5'(q[$urandom_range(0, q.size() - 1)]) : 5'($urandom_range(0, 20));
      Q2_query = (q.size() > 0 && $urandom_range(0, 1) != 0) ?
                 5'(q[$urandom_range(0, q.size() - 1)]) : 5'($urandom_range(0, 20));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order reorder buffer for the out-of-order core. Entries are allocated at dispatch and filled from the arithmetic and load/store CDB broadcasts. It answers the issue stage's two operand-ready queries combinationally, and commits one finished entry per cycle to the register file. It produces the `Q*_ready_from_rob` / `V*_result_from_rob` signals that the issue-stage forwarding logic consumes.

## Interface
Parameters:
- `ROB_SIZE`, 16, number of entries; IDs are 1..`ROB_SIZE`, ID 0 (`ZERO_ROB`) is reserved for "no dependency".
- `ROB_ID_W`, 5, width of `ROB_ID_TYPE`; must satisfy 2^`ROB_ID_W` > `ROB_SIZE`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rdy` in 1: global enable; low freezes all state.
- `alloc_valid` in 1: dispatch requests one entry this cycle.
- `alloc_rd` in 5: destination register of the allocated instruction; 0 means no register write.
- `alloc_rob_id` out `ROB_ID_W`: ID the next allocation will receive (tail).
- `rob_full` out 1: no free entry; an allocation this cycle is ignored.
- `valid_from_Arith_unit_cdb`, `rob_id_from_Arith_unit_cdb`, `result_from_Arith_unit_cdb` in 1/`ROB_ID_W`/32: arithmetic CDB.
- `valid_from_LS_unit_cdb`, `rob_id_from_LS_unit_cdb`, `result_from_LS_unit_cdb` in 1/`ROB_ID_W`/32: LS CDB.
- `Q1_query`, `Q2_query` in `ROB_ID_W`: tags read from the regfile for operands 1/2.
- `Q1_ready_from_rob`, `Q2_ready_from_rob` out 1: queried entry is busy and has its result.
- `V1_result_from_rob`, `V2_result_from_rob` out 32: result of the queried entry.
- `commit_valid` out 1: one-cycle pulse; the regfile writes `commit_value` to `commit_rd` and clears its tag if the tag equals `commit_rob_id`.
- `commit_rd` out 5, `commit_value` out 32, `commit_rob_id` out `ROB_ID_W`: committed entry's data.
- `flush` in 1: mispredict flush (see Configuration).

## Operation
- Circular buffer. Each entry holds: busy, ready, rd[4:0], value[31:0]. State also includes head ID, tail ID and count (0..`ROB_SIZE`).
- Allocate: if `alloc_valid && !rob_full && rdy`, entry[tail] becomes busy=1, ready=0, rd=`alloc_rd`. Tail advances; `ROB_SIZE` wraps to 1, never to 0.
- Writeback: for each CDB with valid set, if entry[id] is busy, set ready=1 and value=result. A CDB write to a non-busy entry or to ID 0 is ignored.
  - Both CDBs may target different entries in the same cycle; both are written.
  - Both CDBs targeting the same ID is illegal upstream; if it occurs, LS wins.
- Commit: if entry[head] is busy and ready, and `rdy`, register the commit outputs with `commit_valid=1`, clear entry[head].busy, and advance head with the same wrap. Otherwise `commit_valid=0`.
  - `commit_rd`, `commit_value` and `commit_rob_id` hold their last values when `commit_valid=0`.
  - Entries with rd=0 commit normally with `commit_rd=0`; the regfile ignores x0.
- Count update: +1 on allocate, −1 on commit, unchanged when both happen in the same cycle.
- Query, combinational, per operand: ready = (Q≠0) && busy[Q] && ready[Q]; V = value[Q] when ready, else 0.
  - A query tag of 0 gives ready=0 and V=0.
  - Same-cycle CDB hits are not forwarded here; the issue forwarding logic covers them.
- Outputs: `rob_full = (count == ROB_SIZE)`, from registered count; `alloc_rob_id = tail`.

## Timing
- Reset values:
  - Every entry busy=0 and ready=0; head=1, tail=1, count=0.
  - `commit_valid=0`, `commit_rd=0`, `commit_value=0`, `commit_rob_id=0`.
  - `rob_full=0`, `alloc_rob_id=1`, query outputs 0.
- Allocate in cycle N: entry is busy from N+1 and `alloc_rob_id` advances at N+1.
- CDB write in cycle N: query ready from N+1. The earliest commit decision is at edge N+1, so `commit_valid` rises in cycle N+2.
- Commit throughput: 1 entry per cycle; back-to-back ready entries give consecutive `commit_valid` pulses.
- Full with a simultaneous commit: allocation is still refused that cycle (registered full) and accepted the next cycle.
- `rdy=0`: no allocate, writeback or commit; `commit_valid` registers 0; CDB data arriving that cycle is lost (upstream stalls too).
- `rst` mid-operation: immediately returns to the reset state regardless of `clk`.

## Configuration
- `ROB_FLUSH_EN` defined:
  - `flush=1` at edge N makes all entries busy=0, head=tail=1, count=0, `commit_valid=0` from N+1.
  - Allocate, CDB writes and commit in cycle N are discarded.
  - `flush` has priority over everything except `rst`.
- Not defined: the `flush` port exists but is ignored; the buffer is only cleared by `rst`.

## Test plan
- Reset, then allocate rd=5, 6, 7 in three consecutive cycles → IDs 1, 2, 3; `alloc_rob_id=4`; count=3; `commit_valid` stays 0.
- Arith CDB id=2 value 0x22, then LS CDB id=1 value 0x11 → `Q1_query=2` reports ready with V=0x22 one cycle after its CDB write. Commits are id1 (rd=5, 0x11) then id2 (rd=6, 0x22) in consecutive cycles; id3 does not commit.
- Fill all 16 entries → `rob_full=1` and a 17th `alloc_valid` is ignored. Make the head ready and commit it while `alloc_valid` is held → allocation accepted one cycle after the commit, with tail wrapped to ID 1.
- Both CDBs in one cycle to IDs 4 and 9 with values 0xA and 0xB → both entries ready next cycle; `Q1_query=4` returns 0xA and `Q2_query=9` returns 0xB.
- Query ID 0 and a non-busy ID, plus a CDB write to a non-busy ID → ready=0 and V=0; no commit occurs.
- With `ROB_FLUSH_EN`, 5 busy entries and flush asserted together with `alloc_valid` → next cycle count=0, `alloc_rob_id=1`, `commit_valid=0`. Without the macro, the same stimulus leaves count=6.
